// File: rtl/mdec_stream_decode_pkg.sv
// Shared MDEC constants, block codes and the coefficient payload carried to the scaling stage.
package mdec_stream_decode_pkg;

  typedef logic [2:0] MDEC_BLCK;

  localparam MDEC_BLCK BLK_Y1 = 3'd0;
  localparam MDEC_BLCK BLK_Y2 = 3'd1;
  localparam MDEC_BLCK BLK_Y3 = 3'd2;
  localparam MDEC_BLCK BLK_Y4 = 3'd3;
  localparam MDEC_BLCK BLK_CR = 3'd4;
  localparam MDEC_BLCK BLK_CB = 3'd5;

  localparam int unsigned K_W = 6;
  localparam logic [15:0] MDEC_EOB   = 16'hFE00;
  localparam logic [5:0]  DC_SCALE   = 6'd8;
  localparam logic [5:0]  FULL_SCALE = 6'd16;

  typedef struct packed {
    logic [9:0]     data;
    logic [5:0]     scale;
    logic           isDC;
    logic [K_W-1:0] linearIndex;
    MDEC_BLCK       blockNum;
  } coefBus_t;

  // Colour macroblock order: Cr, Cb, Y1..Y4, then wrap
  function automatic MDEC_BLCK nextBlk(input MDEC_BLCK b);
    case (b)
      BLK_CR:  return BLK_CB;
      BLK_CB:  return BLK_Y1;
      BLK_Y1:  return BLK_Y2;
      BLK_Y2:  return BLK_Y3;
      BLK_Y3:  return BLK_Y4;
      default: return BLK_CR;
    endcase
  endfunction

endpackage

// File: rtl/mdec_stream_decode_zigzag_rom.sv
// Combinational 64x6 zigzag table: stream position k -> raster index.
module mdec_zigzag_rom
  import mdec_stream_decode_pkg::*;
(
  input  logic [K_W-1:0] i_k,
  output logic [K_W-1:0] o_raster
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  assign o_raster = ZZ[i_k];

endmodule

// File: rtl/mdec_stream_decode.sv
// MDEC RLE/raw halfword decoder feeding the coefficient scaling stage.
// Optional MDEC_STREAM_DEBUG_EN exposes the last accepted halfword on o_debug.
module mdec_stream_decode
  import mdec_stream_decode_pkg::*;
#(
  parameter int unsigned FULL_BLK_LEN = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_startCmd,
  input  logic           i_color,
  input  logic           i_fullBlockType,
  input  logic           i_dataWrt,
  input  logic [15:0]    i_dataIn,
  output logic           o_ready,
  input  logic           i_freezePipe,
  output logic           o_dataWrt,
  output logic [9:0]     o_dataOut,
  output logic [5:0]     o_scale,
  output logic           o_isDC,
  output logic [K_W-1:0] o_index,
  output logic [K_W-1:0] o_linearIndex,
  output MDEC_BLCK       o_blockNum,
  output logic           o_fullBlockType,
  output logic           o_matrixComplete,
  output logic [15:0]    o_debug
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AC   = 2'd1;
  localparam logic [1:0] ST_SKIP = 2'd2;
  localparam logic [1:0] ST_RAW  = 2'd3;

  logic [1:0]     state, stateNxt;
  logic [K_W-1:0] k, kNxt;
  logic [5:0]     scaleReg, scaleRegNxt;
  MDEC_BLCK       blkPtr, blkPtrNxt, curBlk, curBlkNxt, startBlk, advBlk;
  logic           colorLat, colorLatNxt, fullLat, fullLatNxt;
  logic           wrtQ, wrtNxt, cmplQ, cmplNxt, fullOutQ, fullOutNxt;
  coefBus_t       coefQ, coefNxt;
  logic [K_W-1:0] indexQ, zzRaster;
  logic [6:0]     kn;
  logic           accept;

  assign o_ready  = !i_freezePipe & !i_rst & !i_startCmd;
  assign accept   = i_dataWrt & o_ready;
  assign kn       = 7'(k) + 7'(i_dataIn[15:10]) + 7'd1;
  assign startBlk = i_color ? blkPtr : BLK_Y1;
  // Monochrome parks the pointer on Cr so a later colour command starts cleanly
  assign advBlk   = colorLat ? nextBlk(curBlk) : BLK_CR;

  // Raster index always tracks the (possibly held) linear index
  mdec_zigzag_rom u_zigzag (
    .i_k      (coefNxt.linearIndex),
    .o_raster (zzRaster)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      scaleReg <= '0;
      blkPtr   <= BLK_CR;
      curBlk   <= BLK_Y1;
      colorLat <= 1'b0;
      fullLat  <= 1'b0;
      wrtQ     <= 1'b0;
      cmplQ    <= 1'b0;
      fullOutQ <= 1'b0;
      coefQ    <= '0;
      indexQ   <= '0;
    end else begin
      state    <= stateNxt;
      k        <= kNxt;
      scaleReg <= scaleRegNxt;
      blkPtr   <= blkPtrNxt;
      curBlk   <= curBlkNxt;
      colorLat <= colorLatNxt;
      fullLat  <= fullLatNxt;
      wrtQ     <= wrtNxt;
      cmplQ    <= cmplNxt;
      fullOutQ <= fullOutNxt;
      coefQ    <= coefNxt;
      indexQ   <= zzRaster;
    end
  end

  always_comb begin
    stateNxt    = state;
    kNxt        = k;
    scaleRegNxt = scaleReg;
    blkPtrNxt   = blkPtr;
    curBlkNxt   = curBlk;
    colorLatNxt = colorLat;
    fullLatNxt  = fullLat;
    wrtNxt      = wrtQ;
    cmplNxt     = cmplQ;
    fullOutNxt  = fullOutQ;
    coefNxt     = coefQ;
    if (!i_freezePipe) begin
      wrtNxt  = 1'b0;
      cmplNxt = 1'b0;
    end
    if (i_startCmd) begin
      stateNxt  = ST_IDLE;
      kNxt      = '0;
      blkPtrNxt = BLK_CR;
    end else if (accept) begin
      case (state)
        ST_IDLE: begin
          colorLatNxt = i_color;
          fullLatNxt  = i_fullBlockType;
          curBlkNxt   = startBlk;
          fullOutNxt  = i_fullBlockType;
          if (i_fullBlockType) begin
            wrtNxt   = 1'b1;
            coefNxt  = '{data: i_dataIn[9:0], scale: FULL_SCALE, isDC: 1'b1,
                         linearIndex: '0, blockNum: startBlk};
            kNxt     = K_W'(1);
            stateNxt = ST_RAW;
          end else if (i_dataIn != MDEC_EOB) begin
            scaleRegNxt = i_dataIn[15:10];
            wrtNxt      = 1'b1;
            coefNxt     = '{data: i_dataIn[9:0], scale: DC_SCALE, isDC: 1'b1,
                            linearIndex: '0, blockNum: startBlk};
            kNxt        = '0;
            stateNxt    = ST_AC;
          end
        end
        ST_AC: begin
          fullOutNxt = fullLat;
          if (i_dataIn == MDEC_EOB || kn > 7'd63) begin
            // EOB or run past the end both close the block; overflow then skips to EOB
            cmplNxt          = 1'b1;
            coefNxt.blockNum = curBlk;
            blkPtrNxt        = advBlk;
            kNxt             = '0;
            stateNxt         = (i_dataIn == MDEC_EOB) ? ST_IDLE : ST_SKIP;
          end else begin
            wrtNxt  = 1'b1;
            coefNxt = '{data: i_dataIn[9:0], scale: scaleReg, isDC: 1'b0,
                        linearIndex: kn[K_W-1:0], blockNum: curBlk};
            kNxt    = kn[K_W-1:0];
          end
        end
        ST_SKIP: begin
          if (i_dataIn == MDEC_EOB) stateNxt = ST_IDLE;
        end
        default: begin
          fullOutNxt = fullLat;
          wrtNxt     = 1'b1;
          coefNxt    = '{data: i_dataIn[9:0], scale: FULL_SCALE, isDC: (k == '0),
                         linearIndex: k, blockNum: curBlk};
          if (k == K_W'(FULL_BLK_LEN - 1)) begin
            cmplNxt   = 1'b1;
            blkPtrNxt = advBlk;
            kNxt      = '0;
            stateNxt  = ST_IDLE;
          end else begin
            kNxt = k + K_W'(1);
          end
        end
      endcase
    end
  end

  assign o_dataWrt        = wrtQ;
  assign o_matrixComplete = cmplQ;
  assign o_fullBlockType  = fullOutQ;
  assign o_dataOut        = coefQ.data;
  assign o_scale          = coefQ.scale;
  assign o_isDC           = coefQ.isDC;
  assign o_linearIndex    = coefQ.linearIndex;
  assign o_blockNum       = coefQ.blockNum;
  assign o_index          = indexQ;

`ifdef MDEC_STREAM_DEBUG_EN
  logic [15:0] debugQ;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       debugQ <= '0;
    else if (accept) debugQ <= i_dataIn;
  end

  assign o_debug = debugQ;
`else
  assign o_debug = 16'd0;
`endif

endmodule
